// File: rtl/mux8to1_rr_sched.sv
// rtl/mux8to1_rr_sched.sv - round-robin scheduler driving a shared 8:1 single-bit mux
// Registered sel/grant/dout; tenure capped at MAX_HOLD cycles while others are waiting.
module mux8to1_rr_sched #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       dout
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    sel_nxt;
  logic [7:0]    grant_nxt;
  logic          dout_nxt;

  logic          arb_hit;
  logic [2:0]    arb_idx;
  logic [2:0]    cand;
  logic          release_now;

  // Rotating priority search: walking offsets downward lets the smallest offset from ptr win.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr;
    cand    = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // While in GRANT, sel always names the current holder.
  assign release_now = (state == GRANT) &&
                       (!req[sel] || ((cnt == CNT_MAX) && ((req & ~grant) != 8'h00)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= '0;
      sel   <= 3'd0;
      grant <= 8'h00;
      dout  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
      grant <= grant_nxt;
      dout  <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_hit) state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = GAP;
      GAP:     state_nxt = arb_hit ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == GRANT);
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    grant_nxt = grant;
    dout_nxt  = (state == GRANT) ? din[sel] : 1'b0;
    case (state)
      IDLE, GAP: begin
        if (arb_hit) begin
          sel_nxt   = arb_idx;
          grant_nxt = 8'(1) << arb_idx;
          cnt_nxt   = CNT_ONE;
        end else begin
          grant_nxt = 8'h00;
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_nxt = 8'h00;
          ptr_nxt   = sel + 3'd1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        grant_nxt = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_mux8to1_rr_sched.sv
// tb/tb_mux8to1_rr_sched.sv - self-checking bench for mux8to1_rr_sched
// Directed scenarios then random traffic, checked against a holder/pointer reference model.
module tb_mux8to1_rr_sched;

  localparam int MAX_HOLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req   = 8'h00;
  logic [7:0] din   = 8'h00;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic       dout;

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the mux (-1 = nobody), how long, and where the search starts.
  int         m_holder = -1;
  int         m_ptr    = 0;
  int         m_cnt    = 0;
  logic [2:0] m_sel    = 3'd0;
  logic       m_dout   = 1'b0;

  mux8to1_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .din   (din),
    .sel   (sel),
    .grant (grant),
    .busy  (busy),
    .dout  (dout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic       nd;
    logic [7:0] mine;
    logic       found;
    if (reset) begin
      m_holder = -1;
      m_ptr    = 0;
      m_cnt    = 0;
      m_sel    = 3'd0;
      m_dout   = 1'b0;
    end else begin
      nd = (m_holder >= 0) ? din[m_sel] : 1'b0;
      if (m_holder >= 0) begin
        mine = 8'(1) << m_holder;
        if (!req[m_holder] || (m_cnt == MAX_HOLD && (req & ~mine) != 8'h00)) begin
          m_ptr    = (m_holder + 1) % 8;
          m_holder = -1;
        end else if (m_cnt < MAX_HOLD) begin
          m_cnt++;
        end
      end else if (req != 8'h00) begin
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (!found && req[(m_ptr + i) % 8]) begin
            found    = 1'b1;
            m_holder = (m_ptr + i) % 8;
          end
        end
        m_sel = 3'(m_holder);
        m_cnt = 1;
      end
      m_dout = nd;
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d);
    logic [7:0] eg;
    reset = r;
    req   = rq;
    din   = d;
    @(posedge clock);
    model_edge();
    #1;
    eg = (m_holder >= 0) ? (8'(1) << m_holder) : 8'h00;
    chk("grant", grant, eg);
    chk("sel", {5'b0, sel}, {5'b0, m_sel});
    chk("busy", {7'b0, busy}, {7'b0, m_holder >= 0});
    chk("dout", {7'b0, dout}, {7'b0, m_dout});
  endtask

  initial begin
    logic [7:0] rq;
    logic       rs;

    // Reset with everyone requesting
    step(1'b1, 8'hFF, 8'hFF);
    step(1'b1, 8'hFF, 8'hFF);
    chk("reset_grant", grant, 8'h00);

    // Single requester
    step(1'b0, 8'h08, 8'h55);
    chk("single_grant", grant, 8'h08);
    chk("single_sel", {5'b0, sel}, 8'd3);
    step(1'b0, 8'h08, 8'h55);
    chk("single_dout", {7'b0, dout}, 8'h00);
    step(1'b0, 8'h00, 8'h55);
    chk("single_release", grant, 8'h00);
    step(1'b0, 8'h00, 8'h55);
    step(1'b0, 8'h00, 8'h55);

    // Full round-robin with all requesters held
    step(1'b1, 8'h00, 8'h00);
    step(1'b0, 8'hFF, 8'hA5);
    chk("rr_first", grant, 8'h01);
    for (int i = 0; i < 8 * (MAX_HOLD + 1) + 2; i++) step(1'b0, 8'hFF, 8'(i * 37));

    // Lone holder keeps the mux beyond MAX_HOLD
    step(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h20, 8'hFF);
      chk("lone_grant", grant, 8'h20);
    end

    // Pointer wrap after holder 6 releases
    step(1'b1, 8'h00, 8'h00);
    step(1'b0, 8'h40, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h41, 8'h00);
    chk("wrap_grant", grant, 8'h01);

    // Reset in the middle of a tenure
    step(1'b1, 8'h00, 8'h00);
    step(1'b0, 8'hFF, 8'hFF);
    step(1'b0, 8'hFF, 8'hFF);
    step(1'b1, 8'hFF, 8'hFF);
    chk("midreset_grant", grant, 8'h00);
    chk("midreset_dout", {7'b0, dout}, 8'h00);
    step(1'b0, 8'h81, 8'hFF);
    chk("midreset_regrant", grant, 8'h01);

    // Random traffic with sticky requests
    rq = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) rq = 8'($urandom) & 8'($urandom);
      rs = ($urandom_range(0, 59) == 0);
      step(rs, rq, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
